uart_cmd_responder: RTL and testbench
=====================================

# uart_cmd_responder

Byte-level command responder on the far end of the host serial link. It consumes bytes delivered by the UART receiver, parses 3- or 4-byte read/write command packets, and executes them as single transactions on an 8-bit local memory bus. It returns one response byte per packet through the UART transmitter. It sits between the `uart` instance and on-chip registers/RAM, and gives the host debug/configuration access.

## Interface
- `ADDR_WIDTH`, 16: memory bus address width; the two address bytes are concatenated and truncated to this width.
- `TIMEOUT_CYCLES`, 65535: maximum idle `clk` cycles between bytes of one packet before the parser aborts; must be ≥ 1.
- `clk`  in  1  master clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `received`  in  1  one-cycle strobe; `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `recv_error`  in  1  one-cycle strobe; a framing error was detected by the receiver.
- `is_transmitting`  in  1  UART transmitter is busy.
- `transmit`  out  1  one-cycle strobe that starts transmission of `tx_byte`.
- `tx_byte`  out  8  response byte; stable from the `transmit` cycle until return to IDLE.
- `mem_addr`  out  ADDR_WIDTH  bus address.
- `mem_wdata`  out  8  write data.
- `mem_we`  out  1  write request; level, held until `mem_ready`.
- `mem_re`  out  1  read request; level, held until `mem_ready`.
- `mem_rdata`  in  8  read data; valid in the `mem_ready` cycle.
- `mem_ready`  in  1  ends the current bus request.
- `busy`  out  1  high in every state except IDLE.
- `cmd_err`  out  1  one-cycle strobe on NAK, timeout or receive error.

## Operation
- Packets: write = `0x57` ('W'), addr_hi, addr_lo, data → response `0x06` (ACK). Read = `0x52` ('R'), addr_hi, addr_lo → response is the read data byte. Any other first byte → response `0x15` (NAK), with `cmd_err` pulsed.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, RESP, RESP_HOLD.
- IDLE: on `received`, latch the opcode. A valid opcode goes to ADDR_HI. An invalid opcode loads `tx_byte`=`0x15` and goes to RESP.
- ADDR_HI / ADDR_LO / DATA: each advances on `received` and latches the byte. Read goes ADDR_LO → BUS. Write goes ADDR_LO → DATA → BUS.
- BUS: `mem_we` or `mem_re` is asserted, never both. On `mem_ready`, write loads `tx_byte`=`0x06` and read loads `tx_byte`=`mem_rdata`; then go to RESP.
- RESP: wait while `is_transmitting`. When it is low, assert `transmit` for exactly one cycle and go to RESP_HOLD.
- RESP_HOLD: one cycle that covers the UART's registered busy flag, then go to IDLE.
- Timeout counter: cleared on every `received`, counts in ADDR_HI/ADDR_LO/DATA, saturates. Reaching `TIMEOUT_CYCLES` → pulse `cmd_err`, go to IDLE, send no response.
- `recv_error` in any parse state (IDLE..DATA) → pulse `cmd_err`, go to IDLE, no response. In BUS/RESP/RESP_HOLD it is ignored.
- Bytes received in BUS/RESP/RESP_HOLD are discarded silently. The host must wait for the response.
- If `received` and `recv_error` occur in the same cycle, the error wins.

## Timing
- Reset values: `transmit`=0, `tx_byte`=0x00, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_re`=0, `busy`=0, `cmd_err`=0. State is IDLE and the counter is 0.
- All outputs are registered.
- The bus request asserts on the cycle after the final packet byte's `received`. A zero-wait `mem_ready` (high on the first request cycle) ends the request in that cycle.
- `mem_addr`/`mem_wdata` are stable for the whole request. `mem_re`/`mem_we` deassert on the cycle after `mem_ready`.
- From `mem_ready` to `transmit` is a minimum of 2 cycles when the transmitter is idle.
- Reset asserted mid-BUS drops the request immediately (asynchronously). Reset asserted mid-RESP sends no byte.

## Structure
- Shared package `uart_cmd_pkg`: opcode constants `CMD_READ`=0x52 and `CMD_WRITE`=0x57, response constants `RSP_ACK`=0x06 and `RSP_NAK`=0x15, and the state enum. This package is reused by a future host-side initiator model.
- One natural sub-module: `uart_cmd_timeout`, a loadable saturating counter (clear, enable, expired flag).

## Test plan
- Write: bytes 57 12 34 A5 → `mem_we` with addr 0x1234 and wdata 0xA5. After `mem_ready`, exactly one `transmit` with `tx_byte`=0x06.
- Read: 52 00 10, `mem_rdata`=0x3C with ready after 3 wait cycles → `mem_re` held for 4 cycles, then the response byte 0x3C.
- Bad opcode 0x41 → NAK 0x15 and one `cmd_err` pulse. The following 52 00 00 is parsed normally.
- Timeout: 57 12 then silence for `TIMEOUT_CYCLES` → `cmd_err`, IDLE, no `transmit`. The next 52 .. packet succeeds.
- `recv_error` after 57 → abort with no bus access. `is_transmitting` held high in RESP for 50 cycles → `transmit` fires only after it falls.
- `rst` asserted while `mem_re` is high → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the serial command protocol: opcodes, response codes and
// the responder state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StData,
    StBus,
    StResp,
    StRespHold
  } state_e;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Saturating inter-byte idle counter; expired is high once TIMEOUT_CYCLES idle
// cycles have been counted since the last clear.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == Limit);

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses W/R command packets from the UART receiver, runs one local bus transaction
// per packet and returns a single response byte through the UART transmitter.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  recv_error,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  cmd_err
);

  state_e                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [7:0]            tx_byte_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  transmit_d, mem_we_d, mem_re_d, busy_d, cmd_err_d;
  logic                  counting, expired, valid_op, abort;

  assign counting = (state_q == StAddrHi) || (state_q == StAddrLo) || (state_q == StData);
  assign valid_op = (rx_byte == CMD_READ) || (rx_byte == CMD_WRITE);
  // A byte arriving on the expiry cycle still counts; a framing error always wins.
  assign abort    = counting && (recv_error || (!received && expired));

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (received | ~counting),
    .en     (counting),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (received && !recv_error) state_d = valid_op ? StAddrHi : StResp;
      end
      StAddrHi: begin
        if (abort)         state_d = StIdle;
        else if (received) state_d = StAddrLo;
      end
      StAddrLo: begin
        if (abort)         state_d = StIdle;
        else if (received) state_d = is_write_q ? StData : StBus;
      end
      StData: begin
        if (abort)         state_d = StIdle;
        else if (received) state_d = StBus;
      end
      StBus:      if (mem_ready) state_d = StResp;
      StResp:     if (!is_transmitting) state_d = StRespHold;
      StRespHold: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    is_write_d  = is_write_q;
    addr_hi_d   = addr_hi_q;
    tx_byte_d   = tx_byte;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    transmit_d  = 1'b0;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (recv_error) begin
          cmd_err_d = 1'b1;
        end else if (received) begin
          is_write_d = (rx_byte == CMD_WRITE);
          if (!valid_op) begin
            tx_byte_d = RSP_NAK;
            cmd_err_d = 1'b1;
          end
        end
      end
      StAddrHi, StAddrLo, StData: begin
        if (abort) begin
          cmd_err_d = 1'b1;
        end else if (received) begin
          if (state_q == StAddrHi)      addr_hi_d   = rx_byte;
          else if (state_q == StAddrLo) mem_addr_d  = ADDR_WIDTH'({addr_hi_q, rx_byte});
          else                          mem_wdata_d = rx_byte;
        end
      end
      StBus:   if (mem_ready) tx_byte_d = is_write_q ? RSP_ACK : mem_rdata;
      StResp:  transmit_d = !is_transmitting;
      default: ;
    endcase
    mem_we_d = (state_d == StBus) && is_write_d;
    mem_re_d = (state_d == StBus) && !is_write_d;
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_write_q <= 1'b0;
      addr_hi_q  <= 8'h00;
      transmit   <= 1'b0;
      tx_byte    <= 8'h00;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      is_write_q <= is_write_d;
      addr_hi_q  <= addr_hi_d;
      transmit   <= transmit_d;
      tx_byte    <= tx_byte_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_we     <= mem_we_d;
      mem_re     <= mem_re_d;
      busy       <= busy_d;
      cmd_err    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: a packet-level scoreboard plus a bench-side
// memory, with literal expectations at the points of interest.
module tb_uart_cmd_responder;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        recv_error = 1'b0;
  logic        is_transmitting = 1'b0;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic        busy, cmd_err;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .received       (received),
    .rx_byte        (rx_byte),
    .recv_error     (recv_error),
    .is_transmitting(is_transmitting),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .busy           (busy),
    .cmd_err        (cmd_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bench memory (serves the bus) and the model's own view of it.
  logic [7:0]  bmem [256];
  logic [7:0]  model_mem [256];
  logic [24:0] exp_bus [$];   // {is_write, addr, wdata}
  logic [7:0]  exp_rsp [$];
  int          exp_err = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int bus_wait = 0;
  int wait_cnt = 0;
  int ready_cyc = 0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (rst || !(mem_we || mem_re)) begin
      wait_cnt = 0;
    end else if (wait_cnt >= bus_wait) begin
      mem_ready = 1'b1;
      mem_rdata = bmem[mem_addr[7:0]];
      if (mem_we) bmem[mem_addr[7:0]] = mem_wdata;
      ready_cyc = cyc;
      wait_cnt  = 0;
    end else begin
      wait_cnt++;
    end
  end

  // Compare process: bus requests, responses and error pulses against the model.
  logic [24:0] cur = '0;
  logic        bus_active = 1'b0;
  int          tx_count = 0, err_count = 0, re_cycles = 0, tx_cyc = 0;
  logic [7:0]  last_tx = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      bus_active = 1'b0;
    end else begin
      if (mem_we || mem_re) begin
        if (mem_re) re_cycles++;
        if (!bus_active) begin
          bus_active = 1'b1;
          if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
          else cur = exp_bus.pop_front();
        end
        check("bus_we", mem_we, cur[24]);
        check("bus_re", mem_re, !cur[24]);
        check("bus_addr", mem_addr, cur[23:8]);
        if (cur[24]) check("bus_wdata", mem_wdata, cur[7:0]);
      end else begin
        bus_active = 1'b0;
      end
      if (transmit) begin
        tx_count++;
        last_tx = tx_byte;
        tx_cyc  = cyc;
        if (exp_rsp.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_byte", tx_byte, exp_rsp.pop_front());
      end
      if (cmd_err) begin
        err_count++;
        check("cmd_err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    tick(1);
    received = 1'b0;
  endtask

  task automatic send_write(input logic [15:0] a, input logic [7:0] d);
    exp_bus.push_back({1'b1, a, d});
    exp_rsp.push_back(8'h06);
    model_mem[a[7:0]] = d;
    send_byte(8'h57); tick(1);
    send_byte(a[15:8]); tick(1);
    send_byte(a[7:0]); tick(1);
    send_byte(d);
  endtask

  task automatic send_read(input logic [15:0] a);
    exp_bus.push_back({1'b0, a, 8'h00});
    exp_rsp.push_back(model_mem[a[7:0]]);
    send_byte(8'h52); tick(1);
    send_byte(a[15:8]); tick(1);
    send_byte(a[7:0]);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick(1);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_transmit"}, transmit, 0);
    check({tag, "_tx_byte"}, tx_byte, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cmd_err"}, cmd_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int t0, e0, r0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i]      = 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
    end
    bmem[8'h10]      = 8'h3C;
    model_mem[8'h10] = 8'h3C;

    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("reset");

    // Write 57 12 34 A5, zero-wait bus.
    t0 = tx_count;
    send_write(16'h1234, 8'hA5);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, 16'h1234);
    check("wr_wdata", mem_wdata, 8'hA5);
    wait_idle("wr_idle", 30);
    check("wr_tx_count", tx_count - t0, 1);
    check("wr_ack", last_tx, 8'h06);
    check("wr_ready_to_tx", tx_cyc - ready_cyc, 2);

    // Read 52 00 10 with three wait cycles.
    bus_wait = 3;
    r0 = re_cycles;
    send_read(16'h0010);
    wait_idle("rd_idle", 30);
    check("rd_re_cycles", re_cycles - r0, 4);
    check("rd_data", last_tx, 8'h3C);
    bus_wait = 0;

    // Bad opcode then a normal read.
    e0 = err_count;
    t0 = tx_count;
    exp_rsp.push_back(8'h15);
    exp_err++;
    send_byte(8'h41);
    wait_idle("nak_idle", 30);
    check("nak_err_count", err_count - e0, 1);
    check("nak_tx_count", tx_count - t0, 1);
    check("nak_byte", last_tx, 8'h15);
    send_read(16'h0000);
    wait_idle("after_nak_idle", 30);
    check("after_nak_data", last_tx, 8'h5A);

    // Timeout after 57 12.
    t0 = tx_count;
    exp_err++;
    send_byte(8'h57); tick(1);
    send_byte(8'h12);
    tick(TO);
    check("to_not_early", busy, 1);
    tick(1);
    check("to_idle", busy, 0);
    check("to_cmd_err", cmd_err, 1);
    tick(3);
    check("to_no_tx", tx_count - t0, 0);
    send_read(16'h0012);
    wait_idle("after_to_idle", 30);
    check("after_to_data", last_tx, 8'h48);

    // Framing error after 57, then error and byte in the same cycle.
    e0 = err_count;
    exp_err++;
    send_byte(8'h57); tick(1);
    recv_error = 1'b1;
    tick(1);
    recv_error = 1'b0;
    check("rxerr_idle", busy, 0);
    exp_err++;
    send_byte(8'h52); tick(1);
    received = 1'b1; recv_error = 1'b1; rx_byte = 8'h00;
    tick(1);
    received = 1'b0; recv_error = 1'b0;
    check("both_idle", busy, 0);
    tick(2);
    check("rxerr_err_count", err_count - e0, 2);

    // Transmitter busy holds off the response; a stray byte in RESP is discarded.
    is_transmitting = 1'b1;
    t0 = tx_count;
    send_write(16'h0044, 8'h77);
    tick(5);
    send_byte(8'h52);
    tick(44);
    check("txbusy_held", tx_count - t0, 0);
    check("txbusy_busy", busy, 1);
    is_transmitting = 1'b0;
    wait_idle("txbusy_idle", 10);
    check("txbusy_tx_count", tx_count - t0, 1);
    check("txbusy_ack", last_tx, 8'h06);
    tick(5);
    check("stray_discarded", busy, 0);

    // Reset while the read request is pending.
    bus_wait = 1000;
    send_read(16'h0020);
    tick(1);
    check("rstbus_re", mem_re, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_bus");
    void'(exp_rsp.pop_back());
    tick(2);
    rst = 1'b0;
    bus_wait = 0;
    tick(1);

    // Reset while waiting in RESP: no byte must go out.
    is_transmitting = 1'b1;
    t0 = tx_count;
    send_write(16'h0055, 8'h99);
    tick(5);
    check("rstresp_busy", busy, 1);
    check("rstresp_we", mem_we, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    void'(exp_rsp.pop_back());
    is_transmitting = 1'b0;
    tick(10);
    check("rstresp_no_tx", tx_count - t0, 0);
    send_read(16'h0055);
    wait_idle("final_idle", 30);
    check("final_data", last_tx, 8'h99);

    tick(3);
    check("rsp_drained", exp_rsp.size(), 0);
    check("bus_drained", exp_bus.size(), 0);
    check("err_drained", exp_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
